// File: rtl/ad9866_pkg.sv
// Shared definitions for the AD9866 control path: well-known register addresses
// and the command-issue state encoding.
package ad9866_pkg;

  localparam logic [5:0] ADDR_TXGAIN    = 6'h09;
  localparam logic [5:0] ADDR_RXGAIN    = 6'h0a;
  localparam logic [5:0] ADDR_AD9866_WR = 6'h3b;

  typedef enum logic [1:0] {IDLE, RQST, GAP} issue_state_e;

  // Only the gain registers are worth collapsing: a newer value supersedes an older one.
  function automatic logic is_gain_addr(input logic [5:0] addr);
    return (addr == ADDR_TXGAIN) || (addr == ADDR_RXGAIN);
  endfunction

endpackage

// File: rtl/ad9866_cmdq_if.sv
// Host-side command offer and command-slave request/acknowledge bus of the queue.
interface ad9866_cmdq_if;
  logic [5:0]  in_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_rqst;
  logic        cmd_ack;

  modport slave (
    input  in_addr, in_data, in_valid, cmd_ack,
    output in_ready, cmd_addr, cmd_data, cmd_rqst
  );

  modport master (
    output in_addr, in_data, in_valid, cmd_ack,
    input  in_ready, cmd_addr, cmd_data, cmd_rqst
  );
endinterface

// File: rtl/ad9866_cmdq_mem.sv
// Circular command store with push/pop, in-place data overwrite and an address
// search over the queued entries behind the head.
module ad9866_cmdq_mem #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [5:0]               push_addr,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  input  logic                     ovr_en,
  input  logic [$clog2(DEPTH)-1:0] ovr_idx,
  input  logic [31:0]              ovr_data,
  input  logic [5:0]               cmp_addr,
  output logic                     match,
  output logic [$clog2(DEPTH)-1:0] match_idx,
  output logic [5:0]               head_addr,
  output logic [31:0]              head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [5:0]  addr_q [DEPTH];
  logic [5:0]  addr_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [DEPTH-1:0] hit;

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (ovr_en) data_d[ovr_idx] = ovr_data;
    if (push) begin
      addr_d[tail_q] = push_addr;
      data_d[tail_q] = push_data;
      tail_d         = tail_q + AW'(1);
    end
    if (pop) head_d = head_q + AW'(1);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  // Offset from head decides validity; offset 0 is the head and is never a target.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    logic [AW-1:0] offs;
    assign offs    = AW'(gi) - head_q;
    assign hit[gi] = (offs != '0) && ({1'b0, offs} < count_q) && (addr_q[gi] == cmp_addr);
  end

  always_comb begin
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit[i]) match_idx = AW'(i);
    end
  end

  assign match     = |hit;
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];
  assign count     = count_q;
  assign full      = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/ad9866_cmdq.sv
// Command queue ahead of the AD9866 command slave: buffers host writes, coalesces
// pending gain updates and issues one request at a time with an ack timeout.
module ad9866_cmdq
  import ad9866_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TIMEOUT  = 1023,
  parameter int COALESCE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  ad9866_cmdq_if.slave           bus,
  output logic                   drop_pulse,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic          match, full, hit, in_ready, accept, push, ovr_en, pop;
  logic [AW-1:0] match_idx;
  logic [5:0]    head_addr;
  logic [31:0]   head_data;
  logic [AW:0]   count;

  issue_state_e  state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          cmd_rqst_q, cmd_rqst_d;
  logic [5:0]    cmd_addr_q, cmd_addr_d;
  logic [31:0]   cmd_data_q, cmd_data_d;
  logic          drop_q, drop_d;

  ad9866_cmdq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (bus.in_addr),
    .push_data (bus.in_data),
    .pop       (pop),
    .ovr_en    (ovr_en),
    .ovr_idx   (match_idx),
    .ovr_data  (bus.in_data),
    .cmp_addr  (bus.in_addr),
    .match     (match),
    .match_idx (match_idx),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full)
  );

  // A coalescing hit never needs a free slot, so it is accepted even when full.
  always_comb begin
    hit      = (COALESCE != 0) && is_gain_addr(bus.in_addr) && match;
    in_ready = !full || hit;
    accept   = bus.in_valid && in_ready;
    push     = accept && !hit;
    ovr_en   = accept && hit;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_rqst_d = cmd_rqst_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    drop_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          cmd_addr_d = head_addr;
          cmd_data_d = head_data;
          cmd_rqst_d = 1'b1;
          cnt_d      = '0;
          state_d    = RQST;
        end
      end
      RQST: begin
        if (bus.cmd_ack) begin
          pop        = 1'b1;
          cmd_rqst_d = 1'b0;
          state_d    = GAP;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          pop        = 1'b1;
          cmd_rqst_d = 1'b0;
          drop_d     = 1'b1;
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cmd_rqst_q <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_rqst_q <= cmd_rqst_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.cmd_rqst = cmd_rqst_q;
  assign bus.cmd_addr = cmd_addr_q;
  assign bus.cmd_data = cmd_data_q;
  assign drop_pulse   = drop_q;
  assign level        = count;

endmodule

// File: doc/ad9866_cmdq.md
# ad9866_cmdq

Command queue in front of the AD9866 control block's command slave port. It buffers register-write commands from the host control decoder (address 6 bits, data 32 bits) in a small queue. It presents them one at a time over the request/acknowledge interface and holds each request stable until it is acknowledged or times out. Repeated TX/RX gain updates that are still pending are coalesced (last write wins), so a burst of gain changes never stalls the host side behind slow SPI transfers.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, ≥2.
- TIMEOUT, 1023: maximum cycles a request stays asserted without acknowledge before the entry is dropped.
- COALESCE, 1: 1 enables in-place overwrite of pending gain commands; 0 gives a plain FIFO.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_addr  in  6  command address from the host decoder.
- in_data  in  32  command data.
- in_valid  in  1  command offered.
- in_ready  out  1  command accepted when in_valid&in_ready; combinational.
- cmd_addr  out  6  address presented to the command slave; registered.
- cmd_data  out  32  data presented to the command slave; registered.
- cmd_rqst  out  1  request to the command slave; registered.
- cmd_ack  in  1  acknowledge from the command slave.
- drop_pulse  out  1  one-cycle pulse when an entry is dropped on timeout.
- level  out  $clog2(DEPTH)+1  entries held, including the in-flight one.

## Operation
- Storage: circular register array with head/tail pointers and a full/empty count; level = count.
- Issue FSM states:
  - IDLE: if count>0, load the head entry into cmd_addr/cmd_data, set cmd_rqst=1, clear the timeout counter, go to RQST.
  - RQST: cmd_addr/cmd_data/cmd_rqst held constant.
    - If cmd_ack=1: pop the head, cmd_rqst←0, go to GAP.
    - Else if the counter equals TIMEOUT-1: pop the head, cmd_rqst←0, drop_pulse←1, go to GAP.
    - Else increment the counter.
  - GAP: cmd_rqst stays 0 for exactly one cycle, then go to IDLE.
- Acceptance:
  - With COALESCE=0: in_ready = !full.
  - With COALESCE=1: in_ready = !full | match.
- Coalescing:
  - Applies only to addresses 0x09 (TX gain) and 0x0a (RX gain). Address 0x3b (generic AD9866 write) and all others always push.
  - match = a non-head valid entry has the same address. On accept with match, that entry's data is overwritten in place; count, pointers and order are unchanged.
  - The head entry is never a coalescing target, whether or not it is in flight.
  - At most one non-head entry per coalescable address ever exists.
- Simultaneous push and pop in one cycle: both take effect; count unchanged. When full, a pop does not make in_ready high in the same cycle.
- Simultaneous coalescing overwrite and pop: the overwrite targets a non-head entry, so there is no conflict.
- Pointers wrap modulo DEPTH.
- Commands leave in acceptance order, except for coalesced updates.

## Timing
- Reset values:
  - cmd_rqst=0, cmd_addr=0, cmd_data=0, drop_pulse=0.
  - level=0, FSM=IDLE, pointers=0.
  - in_ready=1 once rst is low.
- rst asserted mid-transaction discards all entries; cmd_rqst is 0 after the reset edge.
- Latency, empty queue: a command accepted at edge t gives cmd_rqst=1 after edge t+1.
- cmd_ack is sampled only while cmd_rqst=1. An ack seen at edge t gives cmd_rqst=0 and the pop after edge t. cmd_ack while cmd_rqst=0 is ignored.
- Minimum spacing between requests: cmd_rqst is low for 2 cycles (GAP + IDLE).
- Timeout: cmd_rqst is high for exactly TIMEOUT cycles, then drops. drop_pulse is high in the first low cycle.

## Structure
- Shared package ad9866_pkg holds:
  - ADDR_TXGAIN=6'h09, ADDR_RXGAIN=6'h0a, ADDR_AD9866_WR=6'h3b.
  - The issue-FSM state enum {IDLE, RQST, GAP}.
- One sub-module, ad9866_cmdq_mem: register array with push/pop, an overwrite port, and an address match compare over valid non-head entries. It returns match plus the index of the matching entry.
- Top level holds the issue FSM, the timeout counter and the output registers.

## Test plan
- Single write: addr 0x3b, data 0x0612_0034, ack held 0 for 5 cycles then 1 → cmd_rqst high 6 cycles, cmd_data stable at 0x06120034, level 1→0.
- Coalesce: ack tied 0; push 0x0a/0x40, then 0x09/0x3000_0000, 0x0a/0x20, 0x0a/0x10 → level=3. After releasing ack, the order is 0x0a/0x40, 0x09/0x30000000, 0x0a/0x10.
- Full with DEPTH=8: eight 0x3b pushes with ack held 0 → in_ready=0. A further 0x09 push is refused. Once head 0x3b is popped and an entry 0x09 exists, a second 0x09 is accepted while full.
- Timeout with TIMEOUT=16: ack never asserted → cmd_rqst high 16 cycles, one drop_pulse, next entry requested 2 cycles later.
- Reset mid-RQST with 3 entries → cmd_rqst=0, level=0 after the reset edge; a post-reset push is issued normally.
- COALESCE=0 regression: three 0x0a pushes → three distinct requests in order.
